// File: rtl/keypad_scanner_pkg.sv
// Shared calculator definitions: the scanner FSM states, the key-code width,
// the key-code map used by the calculator core, and a lowest-row helper.
package calc_pkg;

   localparam int KEY_CODE_W = 4;

   typedef enum logic [1:0] {
      ST_SCAN         = 2'd0,
      ST_DEBOUNCE     = 2'd1,
      ST_REPORT       = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } scan_state_t;

   // Key codes are row*4 + col for this keypad layout:
   //   1 2 3 +
   //   4 5 6 -
   //   7 8 9 *
   //   C 0 = /
   localparam logic [KEY_CODE_W-1:0] KEY_1   = 4'd0;
   localparam logic [KEY_CODE_W-1:0] KEY_2   = 4'd1;
   localparam logic [KEY_CODE_W-1:0] KEY_3   = 4'd2;
   localparam logic [KEY_CODE_W-1:0] KEY_ADD = 4'd3;
   localparam logic [KEY_CODE_W-1:0] KEY_4   = 4'd4;
   localparam logic [KEY_CODE_W-1:0] KEY_5   = 4'd5;
   localparam logic [KEY_CODE_W-1:0] KEY_6   = 4'd6;
   localparam logic [KEY_CODE_W-1:0] KEY_SUB = 4'd7;
   localparam logic [KEY_CODE_W-1:0] KEY_7   = 4'd8;
   localparam logic [KEY_CODE_W-1:0] KEY_8   = 4'd9;
   localparam logic [KEY_CODE_W-1:0] KEY_9   = 4'd10;
   localparam logic [KEY_CODE_W-1:0] KEY_MUL = 4'd11;
   localparam logic [KEY_CODE_W-1:0] KEY_CLR = 4'd12;
   localparam logic [KEY_CODE_W-1:0] KEY_0   = 4'd13;
   localparam logic [KEY_CODE_W-1:0] KEY_EQ  = 4'd14;
   localparam logic [KEY_CODE_W-1:0] KEY_DIV = 4'd15;

   // Index of the lowest active-low row; meaningful only when some row is low.
   function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows_n[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key handshake between the scanner (master) and the calculator core (slave).
// key_valid rises with a new key_code and holds both steady until the consumer
// pulses key_ack for one cycle; key_valid drops the cycle after the ack. A new
// key accepted while key_valid is still high sets the sticky overrun flag,
// which the same ack clears. key_held follows the physical key.
interface keypad_scanner_if import calc_pkg::*; ;

   logic [KEY_CODE_W-1:0] key_code;
   logic                  key_valid;
   logic                  key_ack;
   logic                  key_held;
   logic                  overrun;

   modport master (
      output key_code,
      output key_valid,
      output key_held,
      output overrun,
      input  key_ack
   );

   modport slave (
      input  key_code,
      input  key_valid,
      input  key_held,
      input  overrun,
      output key_ack
   );

endinterface

// File: rtl/keypad_scanner_tick_gen.sv
// Single-cycle enable every DIV clocks; replaces derived-clock dividers.
module tick_gen #(
   parameter int DIV = 5
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(DIV - 1));

   // Free-running counter 0..DIV-1, wrapping on the tick cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       count <= '0;
      else if (tick) count <= '0;
      else           count <= count + 1'b1;
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives one column at a time, debounces a single key
// press and release, and presents the key code over the key handshake.
module keypad_scanner import calc_pkg::*; #(
   parameter int TICK_DIV = 5,
   parameter int DEBOUNCE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       row_n,
   output logic [3:0]       col_n,
   keypad_scanner_if.master kbus,
   output scan_state_t      dbg_state
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   logic                  tick;
   logic [3:0]            row_meta, row_s;
   scan_state_t           state, state_next;
   logic [1:0]            col, col_next;
   logic [1:0]            cand_row, cand_next;
   logic [CNT_W-1:0]      cnt, cnt_next;
   logic [KEY_CODE_W-1:0] code_q, code_next;
   logic                  valid_q, valid_next;
   logic                  held_q, held_next;
   logic                  ovr_q, ovr_next;

   tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Two-flop synchronizer for the asynchronous rows; idles high (no key).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta <= 4'hF;
         row_s    <= 4'hF;
      end else begin
         row_meta <= row_n;
         row_s    <= row_meta;
      end
   end

   // State, scan position and handshake registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_SCAN;
         col      <= 2'd0;
         col_n    <= 4'b1110;
         cand_row <= 2'd0;
         cnt      <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
         held_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state    <= state_next;
         col      <= col_next;
         col_n    <= ~(4'b0001 << col_next);
         cand_row <= cand_next;
         cnt      <= cnt_next;
         code_q   <= code_next;
         valid_q  <= valid_next;
         held_q   <= held_next;
         ovr_q    <= ovr_next;
      end
   end

   // Next-state logic: scan, debounce the candidate row, report, await release.
   always_comb begin
      state_next = state;
      col_next   = col;
      cand_next  = cand_row;
      cnt_next   = cnt;
      code_next  = code_q;
      valid_next = valid_q & ~kbus.key_ack;
      ovr_next   = ovr_q & ~kbus.key_ack;
      held_next  = held_q;

      case (state)
         ST_SCAN: begin
            if (tick) begin
               if (row_s != 4'hF) begin
                  cand_next  = lowest_low_row(row_s);
                  cnt_next   = CNT_W'(1);
                  state_next = ST_DEBOUNCE;
               end else begin
                  col_next = col + 2'd1;
               end
            end
         end

         ST_DEBOUNCE: begin
            if (tick) begin
               if (!row_s[cand_row]) begin
                  cnt_next = cnt + 1'b1;
                  if (cnt_next == CNT_W'(DEBOUNCE)) state_next = ST_REPORT;
               end else begin
                  state_next = ST_SCAN;
                  col_next   = col + 2'd1;
               end
            end
         end

         ST_REPORT: begin
            // A coincident ack is consumed by the old key; the new one stands.
            code_next  = {cand_row, col};
            valid_next = 1'b1;
            if (valid_q && !kbus.key_ack) ovr_next = 1'b1;
            held_next  = 1'b1;
            cnt_next   = '0;
            state_next = ST_WAIT_RELEASE;
         end

         ST_WAIT_RELEASE: begin
            if (tick) begin
               if (row_s[cand_row]) begin
                  cnt_next = cnt + 1'b1;
                  if (cnt_next == CNT_W'(DEBOUNCE)) begin
                     held_next  = 1'b0;
                     state_next = ST_SCAN;
                     col_next   = col + 2'd1;
                  end
               end else begin
                  cnt_next = '0;
               end
            end
         end

         default: state_next = ST_SCAN;
      endcase
   end

   assign kbus.key_code  = code_q;
   assign kbus.key_valid = valid_q;
   assign kbus.key_held  = held_q;
   assign kbus.overrun   = ovr_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model closes row/column contacts,
// and the expected timing and key codes come from tick arithmetic and a small
// pending-key model.
module tb_keypad_scanner;
   import calc_pkg::*;

   localparam int TD = 5;
   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   scan_state_t dbg_state;
   logic [15:0] pressed = '0;

   int total = 0;
   int bad   = 0;
   int tcyc  = 0;

   logic [3:0] exp_q[$];
   bit         m_valid = 1'b0;
   bit         m_ovr   = 1'b0;

   keypad_scanner_if kbus ();

   keypad_scanner #(.TICK_DIV(TD), .DEBOUNCE(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .row_n     (row_n),
      .col_n     (col_n),
      .kbus      (kbus),
      .dbg_state (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [3:0] col_pat(input int c);
      logic [3:0] p;
      p = 4'b0001 << (c % 4);
      return ~p;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock; inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      tcyc++;
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_col_n"},     col_n, 4'b1110);
      check({tag, "_key_code"},  kbus.key_code, 0);
      check({tag, "_key_valid"}, kbus.key_valid, 0);
      check({tag, "_key_held"},  kbus.key_held, 0);
      check({tag, "_overrun"},   kbus.overrun, 0);
      check({tag, "_state"},     dbg_state, ST_SCAN);
   endtask

   task automatic release_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tcyc = 0;
      m_valid = 1'b0;
      m_ovr = 1'b0;
      exp_q.delete();
   endtask

   // Wait for the scan to newly arrive at column c (a tick boundary).
   task automatic wait_col(input int c);
      logic [3:0] tgt, prev;
      int n;
      tgt = col_pat(c);
      n = 0;
      prev = col_n;
      step();
      while (!(col_n == tgt && prev != tgt) && n < 6*TD) begin
         prev = col_n;
         step();
         n++;
      end
      check("wait_col_reached", col_n, tgt);
      check("wait_col_phase", tcyc % TD, 0);
   endtask

   task automatic press_key(input logic [15:0] mask, input int c, input logic [3:0] code,
                            input bit ack_rep);
      int t_done;
      wait_col(c);
      pressed = pressed | mask;
      t_done = tcyc + TD - 1 + (DB-1)*TD;
      exp_q.push_back(code);
      while (tcyc < t_done) step();
      check("valid_before_report", kbus.key_valid, m_valid);
      check("held_before_report", kbus.key_held, 0);
      step();
      kbus.key_ack = ack_rep;
      step();
      kbus.key_ack = 1'b0;
      m_ovr = (m_valid && !ack_rep) ? 1'b1 : (ack_rep ? 1'b0 : m_ovr);
      m_valid = 1'b1;
      check("key_valid", kbus.key_valid, 1);
      check("key_code", kbus.key_code, exp_q.pop_front());
      check("overrun", kbus.overrun, m_ovr);
      check("key_held", kbus.key_held, 1);
   endtask

   task automatic release_key(input logic [15:0] mask, input int c);
      int k, f;
      pressed = pressed & ~mask;
      k = tcyc + 2;
      while (k % TD != TD-1) k++;
      f = k + (DB-1)*TD + 1;
      while (tcyc < f-1) step();
      check("held_until_release", kbus.key_held, 1);
      step();
      check("held_released", kbus.key_held, 0);
      check("col_after_release", col_n, col_pat(c + 1));
      check("valid_kept_after_release", kbus.key_valid, m_valid);
   endtask

   task automatic ack_key();
      kbus.key_ack = 1'b1;
      check("valid_during_ack", kbus.key_valid, m_valid);
      step();
      kbus.key_ack = 1'b0;
      m_valid = 1'b0;
      m_ovr = 1'b0;
      check("valid_after_ack", kbus.key_valid, 0);
      check("overrun_after_ack", kbus.overrun, 0);
   endtask

   initial begin
      int r, c, t0;
      bit ack_rep;
      kbus.key_ack = 1'b0;

      // Reset and idle column walk
      release_reset();
      check_reset_values("reset");
      for (int i = 1; i <= 5; i++) begin
         while (tcyc < i*TD - 1) step();
         check("scan_col_before_tick", col_n, col_pat(i - 1));
         step();
         check("scan_col_after_tick", col_n, col_pat(i));
      end

      // Bounce: row0/col1 low for two ticks only
      wait_col(1);
      pressed = 16'h0002;
      t0 = tcyc + TD - 1;
      while (tcyc < t0 + TD + 1) step();
      pressed = '0;
      while (tcyc < t0 + 2*TD + 1) step();
      check("bounce_col_advanced", col_n, 4'b1011);
      check("bounce_no_valid", kbus.key_valid, 0);
      check("bounce_state", dbg_state, ST_SCAN);

      // Clean press of key 6 (row1, col2), release, then ack
      press_key(16'h0001 << 6, 2, KEY_6, 1'b0);
      release_key(16'h0001 << 6, 2);
      ack_key();

      // Rows 1 and 3 together on col0: lowest row wins
      press_key((16'h0001 << 4) | (16'h0001 << 12), 0, 4'd4, 1'b0);
      release_key((16'h0001 << 4) | (16'h0001 << 12), 0);
      ack_key();

      // Overrun, then ack coinciding with the report
      press_key(16'h0001 << 5, 1, KEY_5, 1'b0);
      release_key(16'h0001 << 5, 1);
      press_key(16'h0001 << 10, 2, KEY_9, 1'b0);
      release_key(16'h0001 << 10, 2);
      ack_key();
      press_key(16'h0001 << 3, 3, KEY_ADD, 1'b0);
      release_key(16'h0001 << 3, 3);
      press_key(16'h0001 << 12, 0, KEY_CLR, 1'b1);
      release_key(16'h0001 << 12, 0);

      // Reset during DEBOUNCE
      wait_col(3);
      pressed = 16'h0001 << 11;
      repeat (2*TD) step();
      check("pre_reset_debounce_state", dbg_state, ST_DEBOUNCE);
      rst = 1'b1;
      #1;
      check_reset_values("rst_debounce");
      pressed = '0;
      release_reset();
      while (tcyc < TD - 1) step();
      check("restart_col0", col_n, 4'b1110);
      step();
      check("restart_col1", col_n, 4'b1101);

      // Reset during WAIT_RELEASE
      press_key(16'h0001 << 9, 1, KEY_8, 1'b0);
      repeat (3) step();
      check("pre_reset_wait_state", dbg_state, ST_WAIT_RELEASE);
      rst = 1'b1;
      #1;
      check_reset_values("rst_wait_release");
      pressed = '0;
      release_reset();
      while (tcyc < TD - 1) step();
      check("restart2_col0", col_n, 4'b1110);
      step();
      check("restart2_col1", col_n, 4'b1101);

      // Randomized keys, acks and report-cycle acks against the pending-key model
      for (int i = 0; i < 10; i++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         ack_rep = ($urandom_range(0, 3) == 0);
         press_key(16'h0001 << (r*4 + c), c, 4'(r*4 + c), ack_rep);
         repeat ($urandom_range(0, 2*TD)) step();
         release_key(16'h0001 << (r*4 + c), c);
         if ($urandom_range(0, 1) == 1) ack_key();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad for the calculator front end, debounces one key at a time, and presents a single key code to the calculator core through a valid/ack handshake. All timing derives from a single-cycle scan tick generated from `clk`; no derived clock is produced and every flop runs on `clk`. The block sits between the keypad pins and the operand/operator entry logic.

## Interface
- `TICK_DIV`, default 5: `clk` cycles per scan tick. Must be at least 3.
- `DEBOUNCE`, default 4: number of consecutive agreeing tick samples needed to accept a press, and again to accept a release. Must be at least 2.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `row_n`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_n`  out  4  column drive, active-low one-hot.
- `key_code`  out  4  accepted key, encoded as row*4 + col.
- `key_valid`  out  1  a key is pending; held until acknowledged.
- `key_ack`  in  1  single-cycle pulse from the consumer; clears `key_valid` and `overrun`.
- `key_held`  out  1  high from key acceptance until release is accepted.
- `overrun`  out  1  sticky; a new key was accepted while `key_valid` was still set.

## Operation
- **Row synchronizer:** `row_n` passes through a 2-flop synchronizer. All samples below use the synchronized value.
- **Tick generator:**
  - Counter runs 0..TICK_DIV-1.
  - `tick` is high for one cycle when count = TICK_DIV-1, then the counter wraps to 0.
- **Column index `col`:**
  - Width 2; wraps 3→0.
  - `col_n` = ~(1<<col), registered.
- **FSM states:** SCAN, DEBOUNCE, REPORT, WAIT_RELEASE. Transitions occur only on `tick`, except REPORT.
  - **SCAN:** on `tick`, sample the rows for the current `col`.
    - Any row low: capture `cand_row` (lowest low row index wins), set `cnt`=1, go to DEBOUNCE, keep `col`.
    - No row low: `col`+1.
  - **DEBOUNCE:** on `tick`, test `cand_row` only.
    - Still low: `cnt`+1.
    - When `cnt` reaches DEBOUNCE: go to REPORT.
    - `cand_row` high: go to SCAN with `col`+1; no report.
  - **REPORT:** lasts exactly 1 cycle, regardless of `tick`.
    - `key_code` ← cand_row*4 + col.
    - `key_valid` ← 1.
    - If `key_valid` was already 1 and `key_ack` is not asserted this cycle: `overrun` ← 1.
    - `key_held` ← 1. Set `cnt`=0, go to WAIT_RELEASE.
  - **WAIT_RELEASE:** `col` is held.
    - On `tick` with `cand_row` high: `cnt`+1.
    - On `tick` with `cand_row` low: `cnt`=0.
    - When `cnt` reaches DEBOUNCE: `key_held` ← 0, go to SCAN with `col`+1.
- **`key_ack`:** clears `key_valid` and `overrun` in any state.
  - If `key_ack` coincides with REPORT, the new report wins: `key_valid` stays 1 and `overrun` is not set.
- **Ignored keys:** other keys pressed during DEBOUNCE or WAIT_RELEASE are ignored. Only `cand_row` in the held column is observed.
- **Counters:** `cnt` is sized for DEBOUNCE.

## Timing
- **Reset values:**
  - FSM in SCAN.
  - `col`=0, `col_n`=4'b1110.
  - `key_code`=0, `key_valid`=0, `key_held`=0, `overrun`=0.
  - Tick counter = 0.
  - Synchronizer flops = 1.
- **Mid-operation reset:** `rst` asserted at any point forces the reset values immediately. There is no partial report.
- **First tick:** `tick` first fires in cycle TICK_DIV-1 after reset release. Column steps every TICK_DIV cycles while scanning.
- **Settling:** a column is driven for a full tick period before it is sampled. This covers 2 synchronizer cycles plus at least 1 settling cycle.
- **Press latency:** with a stable press first seen at tick T, `key_valid` rises 1 cycle after tick T + (DEBOUNCE-1) ticks.
- **Release latency:** `key_held` falls 1 cycle after the DEBOUNCE-th consecutive high sample.
- **Ack latency:** `key_valid` falls the cycle after `key_ack`.

## Structure
- Shared package `calc_pkg` holds:
  - the FSM state enum;
  - `KEY_CODE_W`=4;
  - named key-code constants (digits, operators, `=`, clear) used by the calculator core.
- Sub-module `tick_gen` (parameter DIV) produces the single-cycle enable. It is reusable by display multiplexing and replaces derived-clock dividers.

## Test plan
- **Reset:** (TICK_DIV=5, DEBOUNCE=4) release `rst` → all outputs at reset values; `col_n`=1110 until the first tick, then 1101, 1011, 0111, 1110 every 5 cycles.
- **Clean press:** hold row1 low while col2 is driven, stable → `key_code`=6; `key_valid` rises 1 cycle after the 4th agreeing tick and stays high with no ack; release → `key_held` falls after 4 high ticks; `key_ack` → `key_valid`=0.
- **Bounce rejection:** row0/col1 low for 2 ticks, then high → no `key_valid`; `col_n` advances to col2.
- **Multi-row:** rows 1 and 3 low together on col0 → `key_code`=4.
- **Overrun:** accept key 5 without ack, release, accept key 10 → `key_code`=10, `overrun`=1; `key_ack` clears both. Repeat with `key_ack` in the REPORT cycle → `key_valid`=1, `overrun`=0.
- **Reset mid-debounce:** assert `rst` during DEBOUNCE and during WAIT_RELEASE → immediate reset values; scan restarts at col0.
